// File: rtl/fpu_types.sv
// ---------------------------------------------------------------------------
// fpu_types
// Shared FP exception-flag types for the FPU writeback / retire path.
//   FFLAGS_W        : width of an fflags vector {NV,DZ,OF,UF,NX}
//   fflags_t        : one fflags vector
//   FFLAGS_TBL_ID_W : default instruction-ID width of the per-ID flag table
//   fflags_table_t  : flag table at the default depth (2**FFLAGS_TBL_ID_W)
// ---------------------------------------------------------------------------
package fpu_types;

    localparam int FFLAGS_W = 5;

    // Bit positions inside an fflags vector.
    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    typedef logic [FFLAGS_W-1:0] fflags_t;

    localparam int FFLAGS_TBL_ID_W = 3;

    typedef fflags_t fflags_table_t [1 << FFLAGS_TBL_ID_W];

endpackage : fpu_types

// File: rtl/fp_fflags_commit_if.sv
// ---------------------------------------------------------------------------
// fp_fflags_commit_if
// Bundles the issue / writeback / retire / CSR strobes that feed the fflags
// commit block, plus the architectural flag outputs it returns.
//
// Strobe semantics: every *_valid / csr_we is a single-cycle strobe that is
// consumed in the cycle it is high. There is no ready signal; the block never
// stalls and never drops a strobe.
//
//   issue_valid/issue_id              : FP op issued, clears its table entry
//   fp_wb_valid/fp_wb_id/fp_wb_fflags : fp-result writeback flags
//   int_wb_valid/int_wb_id/int_wb_fflags : int-result writeback flags
//   retire_valid/retire_id            : per-port retire strobes, IDs packed
//                                       port p at [p*ID_W +: ID_W]
//   csr_we/csr_wdata                  : CSR write of fflags
//   fflags                            : architectural sticky flags
//   fs_dirty                          : one-cycle pulse on new bit / CSR write
//   fflags_next                       : next fflags value (only when
//                                       FP_FFLAGS_BYPASS_EN is defined)
// Modports: master = pipeline/CSR side, slave = fflags commit block.
// ---------------------------------------------------------------------------
interface fp_fflags_commit_if
    import fpu_types::*;
#(
    parameter int ID_W         = 3,
    parameter int RETIRE_PORTS = 2
);
    logic                         issue_valid;
    logic [ID_W-1:0]              issue_id;
    logic                         fp_wb_valid;
    logic [ID_W-1:0]              fp_wb_id;
    fflags_t                      fp_wb_fflags;
    logic                         int_wb_valid;
    logic [ID_W-1:0]              int_wb_id;
    fflags_t                      int_wb_fflags;
    logic [RETIRE_PORTS-1:0]      retire_valid;
    logic [RETIRE_PORTS*ID_W-1:0] retire_id;
    logic                         csr_we;
    fflags_t                      csr_wdata;
    fflags_t                      fflags;
    logic                         fs_dirty;
`ifdef FP_FFLAGS_BYPASS_EN
    fflags_t                      fflags_next;
`endif

    modport master (
        output issue_valid, issue_id,
        output fp_wb_valid, fp_wb_id, fp_wb_fflags,
        output int_wb_valid, int_wb_id, int_wb_fflags,
        output retire_valid, retire_id,
        output csr_we, csr_wdata,
`ifdef FP_FFLAGS_BYPASS_EN
        input  fflags_next,
`endif
        input  fflags, fs_dirty
    );

    modport slave (
        input  issue_valid, issue_id,
        input  fp_wb_valid, fp_wb_id, fp_wb_fflags,
        input  int_wb_valid, int_wb_id, int_wb_fflags,
        input  retire_valid, retire_id,
        input  csr_we, csr_wdata,
`ifdef FP_FFLAGS_BYPASS_EN
        output fflags_next,
`endif
        output fflags, fs_dirty
    );

endinterface : fp_fflags_commit_if

// File: rtl/fp_fflags_id_table.sv
// ---------------------------------------------------------------------------
// fp_fflags_id_table
// Per-instruction-ID exception-flag storage (2**ID_W entries of fflags_t).
// Each cycle an entry is cleared by an issue of its ID, then OR-ed with any
// fp and/or int writeback flags targeting it, so a same-cycle issue and
// writeback leaves the writeback flags. Read ports forward same-cycle
// writeback flags so a retire can land in the writeback cycle.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   issue_valid_i/issue_id_i : entry clear
//   fp_wb_*_i, int_wb_*_i    : writeback flag merges
//   rd_id_i                  : packed read IDs, port p at [p*ID_W +: ID_W]
//   rd_flags_o               : forwarded entry value per read port
// ---------------------------------------------------------------------------
module fp_fflags_id_table
    import fpu_types::*;
#(
    parameter int ID_W     = 3,
    parameter int RD_PORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid_i,
    input  logic [ID_W-1:0]          issue_id_i,
    input  logic                     fp_wb_valid_i,
    input  logic [ID_W-1:0]          fp_wb_id_i,
    input  fflags_t                  fp_wb_fflags_i,
    input  logic                     int_wb_valid_i,
    input  logic [ID_W-1:0]          int_wb_id_i,
    input  fflags_t                  int_wb_fflags_i,
    input  logic [RD_PORTS*ID_W-1:0] rd_id_i,
    output fflags_t [RD_PORTS-1:0]   rd_flags_o
);

    localparam int DEPTH = 1 << ID_W;

    fflags_t table_q [DEPTH];
    fflags_t table_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            table_d[i] = table_q[i];
            // Clear first so a writeback in the issue cycle survives.
            if (issue_valid_i && (issue_id_i == ID_W'(i))) begin
                table_d[i] = '0;
            end
            if (fp_wb_valid_i && (fp_wb_id_i == ID_W'(i))) begin
                table_d[i] = table_d[i] | fp_wb_fflags_i;
            end
            if (int_wb_valid_i && (int_wb_id_i == ID_W'(i))) begin
                table_d[i] = table_d[i] | int_wb_fflags_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                table_q[i] <= '0;
            end else begin
                table_q[i] <= table_d[i];
            end
        end
    end

    // Forwarding uses the stored entry plus this cycle's writebacks; the
    // stored value is not cleared by a same-cycle issue.
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_flags_o[p] = table_q[rd_id_i[p*ID_W +: ID_W]];
            if (fp_wb_valid_i && (fp_wb_id_i == rd_id_i[p*ID_W +: ID_W])) begin
                rd_flags_o[p] = rd_flags_o[p] | fp_wb_fflags_i;
            end
            if (int_wb_valid_i && (int_wb_id_i == rd_id_i[p*ID_W +: ID_W])) begin
                rd_flags_o[p] = rd_flags_o[p] | int_wb_fflags_i;
            end
        end
    end

endmodule : fp_fflags_id_table

// File: rtl/fp_fflags_commit.sv
// ---------------------------------------------------------------------------
// fp_fflags_commit
// Buffers FP exception flags per instruction ID and folds them into the
// sticky architectural fflags only at retire, so squashed or speculative FP
// ops never set flags. Owns fflags and accepts CSR writes, which take
// priority over (are ordered after) same-cycle retires.
//
// Optional build macro: FP_FFLAGS_BYPASS_EN adds bus.fflags_next, the
// combinational next value of fflags, for same-cycle CSR reads.
//
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears table and flags)
//   bus      : fp_fflags_commit_if.slave (issue/writeback/retire/CSR strobes
//              in, fflags / fs_dirty [/ fflags_next] out)
// ---------------------------------------------------------------------------
module fp_fflags_commit
    import fpu_types::*;
#(
    parameter int ID_W         = 3,
    parameter int RETIRE_PORTS = 2
) (
    input  logic               clk,
    input  logic               rst,
    fp_fflags_commit_if.slave  bus
);

    fflags_t [RETIRE_PORTS-1:0] rd_flags;
    fflags_t                    ret_flags;
    fflags_t                    fflags_q, fflags_d;
    logic                       dirty_q, dirty_d;

    fp_fflags_id_table #(
        .ID_W     (ID_W),
        .RD_PORTS (RETIRE_PORTS)
    ) u_table (
        .clk             (clk),
        .rst             (rst),
        .issue_valid_i   (bus.issue_valid),
        .issue_id_i      (bus.issue_id),
        .fp_wb_valid_i   (bus.fp_wb_valid),
        .fp_wb_id_i      (bus.fp_wb_id),
        .fp_wb_fflags_i  (bus.fp_wb_fflags),
        .int_wb_valid_i  (bus.int_wb_valid),
        .int_wb_id_i     (bus.int_wb_id),
        .int_wb_fflags_i (bus.int_wb_fflags),
        .rd_id_i         (bus.retire_id),
        .rd_flags_o      (rd_flags)
    );

    // Retire reduction; duplicate IDs across ports simply OR together.
    always_comb begin
        ret_flags = '0;
        for (int p = 0; p < RETIRE_PORTS; p++) begin
            if (bus.retire_valid[p]) begin
                ret_flags = ret_flags | rd_flags[p];
            end
        end
    end

    // CSR write wins: a concurrent retire is ordered before it, so its
    // flags are overwritten.
    always_comb begin
        if (bus.csr_we) begin
            fflags_d = bus.csr_wdata;
            dirty_d  = 1'b1;
        end else begin
            fflags_d = fflags_q | ret_flags;
            dirty_d  = |(ret_flags & ~fflags_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_q <= '0;
            dirty_q  <= 1'b0;
        end else begin
            fflags_q <= fflags_d;
            dirty_q  <= dirty_d;
        end
    end

    assign bus.fflags   = fflags_q;
    assign bus.fs_dirty = dirty_q;
`ifdef FP_FFLAGS_BYPASS_EN
    assign bus.fflags_next = fflags_d;
`endif

endmodule : fp_fflags_commit

// File: doc/fp_fflags_commit.md
Name: fp_fflags_commit

Overview:
- Downstream of the FPU top: buffers the per-instruction exception flags produced at FPU writeback (fp and int result paths), keyed by instruction ID.
- Folds them into the architectural fcsr.fflags only when the owning instruction retires, so squashed or speculative FP ops never set flags.
- Owns the sticky fflags register; exposes it to the CSR unit and accepts CSR writes.

Parameters:
- ID_W, 3, instruction ID width; table depth 2**ID_W.
- RETIRE_PORTS, 2, number of instructions retirable per cycle.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- issue_valid  input  1  FP instruction issued; clears its table entry
- issue_id  input  ID_W  ID of issued instruction
- fp_wb_valid  input  1  fp writeback accepted (done & ack)
- fp_wb_id  input  ID_W  ID of fp writeback
- fp_wb_fflags  input  5  flags of fp writeback {NV,DZ,OF,UF,NX}
- int_wb_valid  input  1  int-result writeback accepted
- int_wb_id  input  ID_W  ID of int writeback
- int_wb_fflags  input  5  flags of int writeback
- retire_valid  input  RETIRE_PORTS  per-port retire strobe
- retire_id  input  RETIRE_PORTS*ID_W  per-port retiring ID
- csr_we  input  1  CSR write to fflags, or to the fflags field of fcsr
- csr_wdata  input  5  new fflags value
- fflags  output  5  architectural sticky flags
- fs_dirty  output  1  one-cycle pulse when fflags gains a new bit or is CSR-written

Behaviour:
- Reset: all table entries = 0, fflags = 0, fs_dirty = 0. Reset mid-operation discards all pending flags.
- Table: 2**ID_W entries × 5 bits, written every cycle with these priorities per entry:
  - Base value is the old entry, or 0 if issue_valid && issue_id == entry.
  - OR in fp_wb_fflags if fp_wb_valid targets the entry.
  - OR in int_wb_fflags if int_wb_valid targets the entry.
  - Writeback after clear: same-cycle issue clear and writeback to the same ID yields the writeback flags.
  - Both writebacks to the same ID in one cycle are OR-combined.
- Retire contribution: ret_flags = OR over ports p with retire_valid[p] of fwd(retire_id[p]).
  - fwd(id) = table[id] OR any same-cycle writeback flags to id (writeback-to-retire forwarding, zero bubbles).
  - Duplicate retire IDs across ports are harmless (OR).
- Update, latency 1 cycle:
  - If csr_we: fflags <= csr_wdata. Same-cycle ret_flags are discarded; the CSR op is serialized, so any concurrent retire is architecturally ordered before it.
  - Else: fflags <= fflags | ret_flags.
- Retired entries are not cleared; they are cleared on reissue of that ID.
- fs_dirty (registered): asserted the cycle after the update when
  - csr_we = 1, or
  - (ret_flags & ~fflags) != 0.
- No backpressure: all inputs are single-cycle strobes; the block never stalls.

Optional Feature:
- Macro FP_FFLAGS_BYPASS_EN.
- Defined: adds output fflags_next (5 bits), the combinational next value of fflags. The CSR unit uses it for a read in the same cycle as a retire, avoiding a one-cycle read hazard.
- Undefined: port absent; the CSR unit must stall reads one cycle after any FP retire.

Decomposition:
- fpu_types package:
  - fflags_t (reused)
  - FFLAGS_W = 5
  - typedef fflags_table_t (array of fflags_t)
- Sub-module fp_fflags_id_table:
  - the 2**ID_W flag storage with clear/OR-write logic
  - read ports with writeback forwarding
- The top handles retire reduction, the CSR mux and fs_dirty.

Test Plan:
- Basic: issue id 2; fp_wb id 2 flags 5'b00001; retire id 2 next cycle → fflags = 5'b00001 one cycle later, fs_dirty pulses once.
- Forwarding: issue id 3; same-cycle int_wb id 3 flags 5'b10000 with retire id 3 → fflags = 5'b10000.
- Squash: fp_wb id 4 flags 5'b00100, never retired, then reissue id 4 with wb 0 and retire → fflags stays 0, no fs_dirty.
- Dual retire: ids 1 and 5 pending 5'b00001 and 5'b01000, retired on both ports same cycle → fflags = 5'b01001.
- CSR priority: fflags = 5'b00011; csr_we = 1, wdata = 0 with same-cycle retire of id 6 (flags 5'b00100) → fflags = 0, fs_dirty = 1.
- Sticky/no-dirty: fflags = 5'b00001; retire flags 5'b00001 → fflags unchanged, fs_dirty = 0. Assert rst mid-stream → fflags = 0 and the table cleared (a subsequent retire without writeback adds nothing).
